// File: rtl/fu_alu_issue_queue_pkg.sv
// Shared types and default sizes for the ALU issue queue and its functional unit.
package fu_alu_issue_queue_pkg;

    localparam int XLEN        = 64;
    localparam int ID_W        = 4;
    localparam int IQ_PREG_W   = 6;
    localparam int IQ_NENTRIES = 4;
    localparam int IQ_NWB      = 2;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_ADDW = 4'd10,
        ALU_SUBW = 4'd11
    } alu_op_t;

    typedef struct packed {
        logic [XLEN-1:0]      pc;
        logic [ID_W-1:0]      id;
        alu_op_t              op;
        logic [IQ_PREG_W-1:0] prd;
        logic [XLEN-1:0]      rs1val;
        logic [XLEN-1:0]      rs2val;
    } fu_input_t;

    typedef struct packed {
        logic [XLEN-1:0]      pc;
        logic [ID_W-1:0]      id;
        logic [IQ_PREG_W-1:0] prd;
        logic [XLEN-1:0]      rdval;
    } fu_output_t;

    typedef struct packed {
        logic                 valid;
        fu_input_t            uop;
        logic [IQ_PREG_W-1:0] prs1;
        logic [IQ_PREG_W-1:0] prs2;
        logic                 rs1_rdy;
        logic                 rs2_rdy;
    } iq_entry_t;

endpackage

// File: rtl/fu_alu_issue_queue_if.sv
// Dispatch, writeback-broadcast and result bundle of the ALU issue queue.
interface fu_alu_issue_queue_if
    import fu_alu_issue_queue_pkg::*;
#(
    parameter int NWB    = IQ_NWB,
    parameter int PREG_W = IQ_PREG_W
) ();

    logic                           disp_valid_i;
    logic                           disp_ready_o;
    fu_input_t                      disp_uop_i;
    logic [PREG_W-1:0]              disp_prs1_i;
    logic [PREG_W-1:0]              disp_prs2_i;
    logic                           disp_rs1_rdy_i;
    logic                           disp_rs2_rdy_i;
    logic [NWB-1:0]                 wb_valid_i;
    logic [NWB-1:0][PREG_W-1:0]     wb_prd_i;
    logic [NWB-1:0][XLEN-1:0]       wb_val_i;
    logic                           res_valid_o;
    logic                           res_ready_i;
    fu_output_t                     res_o;

    modport master (
        output disp_valid_i, disp_uop_i, disp_prs1_i, disp_prs2_i,
               disp_rs1_rdy_i, disp_rs2_rdy_i,
               wb_valid_i, wb_prd_i, wb_val_i, res_ready_i,
        input  disp_ready_o, res_valid_o, res_o
    );

    modport slave (
        input  disp_valid_i, disp_uop_i, disp_prs1_i, disp_prs2_i,
               disp_rs1_rdy_i, disp_rs2_rdy_i,
               wb_valid_i, wb_prd_i, wb_val_i, res_ready_i,
        output disp_ready_o, res_valid_o, res_o
    );

endinterface

// File: rtl/fu_alu.sv
// Combinational integer ALU; word ops sign-extend their 32-bit result to XLEN.
module fu_alu
    import fu_alu_issue_queue_pkg::*;
(
    input  fu_input_t  uop_i,
    output fu_output_t res_o
);

    localparam int SH_W = $clog2(XLEN);

    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic [SH_W-1:0]        shamt;
    logic [31:0]            w_sum;
    logic [31:0]            w_dif;
    logic [XLEN-1:0]        rdval;

    // Operation decode and result formation.
    always_comb begin
        a_s   = signed'(uop_i.rs1val);
        b_s   = signed'(uop_i.rs2val);
        shamt = uop_i.rs2val[SH_W-1:0];
        w_sum = uop_i.rs1val[31:0] + uop_i.rs2val[31:0];
        w_dif = uop_i.rs1val[31:0] - uop_i.rs2val[31:0];
        rdval = '0;
        case (uop_i.op)
            ALU_ADD:  rdval = uop_i.rs1val + uop_i.rs2val;
            ALU_SUB:  rdval = uop_i.rs1val - uop_i.rs2val;
            ALU_AND:  rdval = uop_i.rs1val & uop_i.rs2val;
            ALU_OR:   rdval = uop_i.rs1val | uop_i.rs2val;
            ALU_XOR:  rdval = uop_i.rs1val ^ uop_i.rs2val;
            ALU_SLL:  rdval = uop_i.rs1val << shamt;
            ALU_SRL:  rdval = uop_i.rs1val >> shamt;
            ALU_SRA:  rdval = a_s >>> shamt;
            ALU_SLT:  rdval = {{(XLEN-1){1'b0}}, (a_s < b_s)};
            ALU_SLTU: rdval = {{(XLEN-1){1'b0}}, (uop_i.rs1val < uop_i.rs2val)};
            ALU_ADDW: rdval = {{(XLEN-32){w_sum[31]}}, w_sum};
            ALU_SUBW: rdval = {{(XLEN-32){w_dif[31]}}, w_dif};
            default:  rdval = '0;
        endcase
        res_o.pc    = uop_i.pc;
        res_o.id    = uop_i.id;
        res_o.prd   = uop_i.prd;
        res_o.rdval = rdval;
    end

endmodule

// File: rtl/fu_alu_iq_pick.sv
// Lowest-index priority encoder used to select the oldest ready queue entry.
module fu_alu_iq_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Scan from the youngest slot down so the oldest requester is the last write.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/fu_alu_issue_queue.sv
// Collapsing reservation station feeding the integer ALU with a registered result stage.
module fu_alu_issue_queue
    import fu_alu_issue_queue_pkg::*;
#(
    parameter int NENTRIES = IQ_NENTRIES,
    parameter int NWB      = IQ_NWB,
    parameter int PREG_W   = IQ_PREG_W
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush_i,
    fu_alu_issue_queue_if.slave   bus
);

    localparam int IDX_W = (NENTRIES > 1) ? $clog2(NENTRIES) : 1;
    localparam int CNT_W = $clog2(NENTRIES + 1);

    iq_entry_t        ent_q [NENTRIES];
    iq_entry_t        ent_d [NENTRIES];
    iq_entry_t        wk    [NENTRIES+1];
    iq_entry_t        disp_raw;
    iq_entry_t        disp_woken;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] tail;
    logic [NENTRIES-1:0] rdy_vec;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    fu_input_t        sel_uop;
    fu_output_t       alu_out;
    fu_output_t       res_p1;
    logic             vld_p1;
    logic             disp_ready;
    logic             disp_fire;
    logic             issue;

    // Capture a broadcast value into any still-pending source; the lowest
    // matching port is applied last and therefore wins.
    function automatic iq_entry_t wake(
        input iq_entry_t                  e,
        input logic [NWB-1:0]             v,
        input logic [NWB-1:0][PREG_W-1:0] tag,
        input logic [NWB-1:0][XLEN-1:0]   val
    );
        iq_entry_t w;
        w = e;
        for (int p = NWB - 1; p >= 0; p--) begin
            if (!e.rs1_rdy && v[p] && (tag[p] == e.prs1)) begin
                w.rs1_rdy    = 1'b1;
                w.uop.rs1val = val[p];
            end
            if (!e.rs2_rdy && v[p] && (tag[p] == e.prs2)) begin
                w.rs2_rdy    = 1'b1;
                w.uop.rs2val = val[p];
            end
        end
        return w;
    endfunction

    // Readiness comes from registered state only, so a wakeup issues a cycle later.
    always_comb begin
        for (int i = 0; i < NENTRIES; i++) begin
            rdy_vec[i] = ent_q[i].valid && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy;
        end
    end

    fu_alu_iq_pick #(
        .N     (NENTRIES),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (rdy_vec),
        .found (sel_found),
        .idx   (sel_idx)
    );

    // Route the selected entry to the ALU.
    always_comb begin
        sel_uop = ent_q[0].uop;
        for (int i = 0; i < NENTRIES; i++) begin
            if (IDX_W'(i) == sel_idx) begin
                sel_uop = ent_q[i].uop;
            end
        end
    end

    fu_alu u_alu (
        .uop_i (sel_uop),
        .res_o (alu_out)
    );

    assign disp_ready = (cnt_q < CNT_W'(NENTRIES));
    assign issue      = sel_found && (!vld_p1 || bus.res_ready_i) && !flush_i;
    assign disp_fire  = bus.disp_valid_i && disp_ready && !flush_i;
    assign tail       = cnt_q - CNT_W'(issue);

    // Incoming uop sees the same wakeup compare as the stored entries.
    always_comb begin
        disp_raw.valid   = 1'b1;
        disp_raw.uop     = bus.disp_uop_i;
        disp_raw.prs1    = bus.disp_prs1_i;
        disp_raw.prs2    = bus.disp_prs2_i;
        disp_raw.rs1_rdy = bus.disp_rs1_rdy_i;
        disp_raw.rs2_rdy = bus.disp_rs2_rdy_i;
        disp_woken       = wake(disp_raw, bus.wb_valid_i, bus.wb_prd_i, bus.wb_val_i);
    end

    // Next queue image: wake, collapse over the issued slot, append at the tail.
    always_comb begin
        for (int i = 0; i < NENTRIES; i++) begin
            wk[i] = wake(ent_q[i], bus.wb_valid_i, bus.wb_prd_i, bus.wb_val_i);
        end
        wk[NENTRIES] = '0;
        for (int i = 0; i < NENTRIES; i++) begin
            if (issue && (i >= int'(sel_idx))) begin
                ent_d[i] = wk[i+1];
            end else begin
                ent_d[i] = wk[i];
            end
            if (disp_fire && (CNT_W'(i) == tail)) begin
                ent_d[i] = disp_woken;
            end
        end
        cnt_d = cnt_q + CNT_W'(disp_fire) - CNT_W'(issue);
        if (flush_i) begin
            for (int i = 0; i < NENTRIES; i++) begin
                ent_d[i] = '0;
            end
            cnt_d = '0;
        end
    end

    // Queue storage and occupancy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NENTRIES; i++) begin
                ent_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < NENTRIES; i++) begin
                ent_q[i] <= ent_d[i];
            end
            cnt_q <= cnt_d;
        end
    end

    // ---- stage p1: registered ALU result, held while the consumer stalls ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p1 <= 1'b0;
            res_p1 <= '0;
        end else if (flush_i) begin
            vld_p1 <= 1'b0;
        end else if (issue) begin
            vld_p1 <= 1'b1;
            res_p1 <= alu_out;
        end else if (bus.res_ready_i) begin
            vld_p1 <= 1'b0;
        end
    end

    assign bus.disp_ready_o = disp_ready;
    assign bus.res_valid_o  = vld_p1;
    assign bus.res_o        = res_p1;

endmodule

// File: tb/tb_fu_alu_issue_queue.sv
// Scoreboard bench for the ALU issue queue: a queue-based reference model
// predicts issue order and results; a negedge monitor checks each handshake.
module tb_fu_alu_issue_queue;
    import fu_alu_issue_queue_pkg::*;

    localparam int N = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    fu_alu_issue_queue_if #(.NWB(2), .PREG_W(6)) bus ();

    fu_alu_issue_queue #(.NENTRIES(N), .NWB(2), .PREG_W(6)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .flush_i (flush),
        .bus     (bus)
    );

    typedef struct {
        fu_input_t  u;
        logic [5:0] t1;
        logic [5:0] t2;
        bit         r1;
        bit         r2;
    } m_ent_t;

    m_ent_t     mq[$];
    fu_output_t sb[$];
    bit         m_ov = 1'b0;
    int         n_tests = 0;
    int         n_fail = 0;

    function automatic void chk(string name, logic [159:0] act, logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [63:0] ref_alu(fu_input_t u);
        longint a;
        longint b;
        int     w;
        int     sh;
        a  = longint'(u.rs1val);
        b  = longint'(u.rs2val);
        sh = int'(u.rs2val[5:0]);
        case (u.op)
            ALU_ADD:  return u.rs1val + u.rs2val;
            ALU_SUB:  return u.rs1val - u.rs2val;
            ALU_AND:  return u.rs1val & u.rs2val;
            ALU_OR:   return u.rs1val | u.rs2val;
            ALU_XOR:  return u.rs1val ^ u.rs2val;
            ALU_SLL:  return u.rs1val << sh;
            ALU_SRL:  return u.rs1val >> sh;
            ALU_SRA:  return a >>> sh;
            ALU_SLT:  return (a < b) ? 64'd1 : 64'd0;
            ALU_SLTU: return (u.rs1val < u.rs2val) ? 64'd1 : 64'd0;
            ALU_ADDW: begin w = int'(u.rs1val[31:0]) + int'(u.rs2val[31:0]); return longint'(w); end
            ALU_SUBW: begin w = int'(u.rs1val[31:0]) - int'(u.rs2val[31:0]); return longint'(w); end
            default:  return 64'd0;
        endcase
    endfunction

    // Model wakeup: the first matching port (lowest index) supplies the value.
    function automatic m_ent_t m_wake(m_ent_t e);
        for (int p = 0; p < 2; p++) begin
            if (!e.r1 && bus.wb_valid_i[p] && bus.wb_prd_i[p] == e.t1) begin
                e.r1 = 1'b1;
                e.u.rs1val = bus.wb_val_i[p];
            end
            if (!e.r2 && bus.wb_valid_i[p] && bus.wb_prd_i[p] == e.t2) begin
                e.r2 = 1'b1;
                e.u.rs2val = bus.wb_val_i[p];
            end
        end
        return e;
    endfunction

    function automatic fu_input_t rnd_uop();
        fu_input_t u;
        u.pc     = {$urandom, $urandom};
        u.id     = 4'($urandom);
        u.op     = alu_op_t'(4'($urandom_range(0, 11)));
        u.prd    = 6'($urandom);
        u.rs1val = {$urandom, $urandom};
        u.rs2val = {$urandom, $urandom};
        return u;
    endfunction

    task automatic set_idle();
        bus.disp_valid_i   = 1'b0;
        bus.disp_rs1_rdy_i = 1'b0;
        bus.disp_rs2_rdy_i = 1'b0;
        bus.wb_valid_i     = '0;
        flush              = 1'b0;
    endtask

    task automatic set_disp(alu_op_t op, int id, int prd, logic [63:0] a, logic [63:0] b,
                            int t1, int t2, bit r1, bit r2);
        fu_input_t u;
        u.pc     = 64'h1000 + 64'(id);
        u.id     = 4'(id);
        u.op     = op;
        u.prd    = 6'(prd);
        u.rs1val = a;
        u.rs2val = b;
        bus.disp_uop_i     = u;
        bus.disp_prs1_i    = 6'(t1);
        bus.disp_prs2_i    = 6'(t2);
        bus.disp_rs1_rdy_i = r1;
        bus.disp_rs2_rdy_i = r2;
        bus.disp_valid_i   = 1'b1;
    endtask

    // Check visible state against the model, advance the model by one edge
    // using the inputs currently driven, then let the clock edge happen.
    task automatic cyc();
        int         sel;
        bit         acc;
        fu_output_t r;
        m_ent_t     e;
        chk("disp_ready", 160'(bus.disp_ready_o), 160'(mq.size() < N));
        chk("res_valid", 160'(bus.res_valid_o), 160'(m_ov));
        if (flush) begin
            if (m_ov && !bus.res_ready_i) void'(sb.pop_back());
            mq.delete();
            m_ov = 1'b0;
        end else begin
            sel = -1;
            for (int i = 0; i < mq.size(); i++) begin
                if (sel < 0 && mq[i].r1 && mq[i].r2) sel = i;
            end
            acc = bus.disp_valid_i && (mq.size() < N);
            if (sel >= 0 && (!m_ov || bus.res_ready_i)) begin
                r.pc    = mq[sel].u.pc;
                r.id    = mq[sel].u.id;
                r.prd   = mq[sel].u.prd;
                r.rdval = ref_alu(mq[sel].u);
                sb.push_back(r);
                mq.delete(sel);
                m_ov = 1'b1;
            end else if (bus.res_ready_i) begin
                m_ov = 1'b0;
            end
            foreach (mq[i]) mq[i] = m_wake(mq[i]);
            if (acc) begin
                e.u  = bus.disp_uop_i;
                e.t1 = bus.disp_prs1_i;
                e.t2 = bus.disp_prs2_i;
                e.r1 = bus.disp_rs1_rdy_i;
                e.r2 = bus.disp_rs2_rdy_i;
                mq.push_back(m_wake(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every result handshake must match the oldest predicted result.
    initial begin
        fu_output_t exp_r;
        forever begin
            @(negedge clk);
            if (rstn && bus.res_valid_o && bus.res_ready_i) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL res_unexpected: got id %0d expected no result", bus.res_o.id);
                end else begin
                    exp_r = sb.pop_front();
                    chk("res_o", 160'(bus.res_o), 160'(exp_r));
                end
            end
        end
    end

    initial begin
        set_idle();
        bus.disp_uop_i  = '0;
        bus.disp_prs1_i = '0;
        bus.disp_prs2_i = '0;
        bus.wb_prd_i    = '0;
        bus.wb_val_i    = '0;
        bus.res_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;

        // Reset state
        chk("rst_disp_ready", 160'(bus.disp_ready_o), 160'(1));
        chk("rst_res_valid", 160'(bus.res_valid_o), 160'(0));
        chk("rst_res_o", 160'(bus.res_o), 160'(0));

        // Ready ADD 5+7
        bus.res_ready_i = 1'b1;
        set_disp(ALU_ADD, 1, 3, 64'd5, 64'd7, 0, 0, 1'b1, 1'b1);
        cyc();
        set_idle();
        cyc();
        chk("add_valid", 160'(bus.res_valid_o), 160'(1));
        chk("add_rdval", 160'(bus.res_o.rdval), 160'(12));
        chk("add_prd", 160'(bus.res_o.prd), 160'(3));
        cyc();

        // SUB waiting on tag 9, woken via port 1
        set_disp(ALU_SUB, 2, 4, 64'd10, 64'hdead, 1, 9, 1'b1, 1'b0);
        cyc();
        set_idle();
        cyc();
        bus.wb_valid_i  = 2'b10;
        bus.wb_prd_i[1] = 6'd9;
        bus.wb_val_i[1] = 64'd3;
        bus.wb_prd_i[0] = 6'd20;
        cyc();
        set_idle();
        cyc();
        chk("sub_valid", 160'(bus.res_valid_o), 160'(1));
        chk("sub_rdval", 160'(bus.res_o.rdval), 160'(7));
        cyc();

        // Fill the queue behind a stalled result, then drain in order
        bus.res_ready_i = 1'b0;
        set_disp(ALU_ADD, 15, 1, 64'd1, 64'd1, 0, 0, 1'b1, 1'b1);
        cyc();
        for (int k = 0; k < 4; k++) begin
            set_disp(ALU_ADD, k, 10 + k, 64'(k), 64'd100, 0, 0, 1'b1, 1'b1);
            cyc();
        end
        set_idle();
        chk("full_disp_ready", 160'(bus.disp_ready_o), 160'(0));
        bus.res_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("order_valid", 160'(bus.res_valid_o), 160'(1));
            chk("order_id", 160'(bus.res_o.id), 160'(k));
        end
        cyc();

        // Stall with two ready entries queued
        bus.res_ready_i = 1'b0;
        set_disp(ALU_XOR, 9, 5, 64'hff, 64'h0f, 0, 0, 1'b1, 1'b1);
        cyc();
        set_disp(ALU_OR, 10, 6, 64'h1, 64'h2, 0, 0, 1'b1, 1'b1);
        cyc();
        set_disp(ALU_AND, 11, 7, 64'h3, 64'h6, 0, 0, 1'b1, 1'b1);
        cyc();
        set_idle();
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("stall_id", 160'(bus.res_o.id), 160'(9));
            chk("stall_rdval", 160'(bus.res_o.rdval), 160'(64'hf0));
        end
        bus.res_ready_i = 1'b1;
        for (int k = 10; k < 12; k++) begin
            cyc();
            chk("unstall_id", 160'(bus.res_o.id), 160'(k));
        end
        cyc();

        // Flush with three queued, one output and a dispatch in the same cycle
        bus.res_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_disp(ALU_SUB, k, 20 + k, 64'd50, 64'(k), 0, 0, 1'b1, 1'b1);
            cyc();
        end
        set_disp(ALU_ADD, 7, 30, 64'd1, 64'd2, 0, 0, 1'b1, 1'b1);
        flush = 1'b1;
        cyc();
        set_idle();
        chk("flush_res_valid", 160'(bus.res_valid_o), 160'(0));
        chk("flush_disp_ready", 160'(bus.disp_ready_o), 160'(1));
        bus.res_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("flush_empty", 160'(bus.res_valid_o), 160'(0));
        end

        // Randomized traffic with a mid-run asynchronous reset
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                set_idle();
                #2 rstn = 1'b0;
                #1;
                chk("midrst_res_valid", 160'(bus.res_valid_o), 160'(0));
                chk("midrst_disp_ready", 160'(bus.disp_ready_o), 160'(1));
                chk("midrst_res_o", 160'(bus.res_o), 160'(0));
                mq.delete();
                sb.delete();
                m_ov = 1'b0;
                @(posedge clk);
                #1;
                rstn = 1'b1;
            end
            bus.disp_valid_i   = ($urandom_range(0, 9) < 6);
            bus.disp_uop_i     = rnd_uop();
            bus.disp_prs1_i    = 6'($urandom_range(0, 7));
            bus.disp_prs2_i    = 6'($urandom_range(0, 7));
            bus.disp_rs1_rdy_i = 1'($urandom_range(0, 1));
            bus.disp_rs2_rdy_i = 1'($urandom_range(0, 1));
            for (int p = 0; p < 2; p++) begin
                bus.wb_valid_i[p] = 1'($urandom_range(0, 1));
                bus.wb_prd_i[p]   = 6'($urandom_range(0, 7));
                bus.wb_val_i[p]   = {$urandom, $urandom};
            end
            bus.res_ready_i = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 49) == 0);
            cyc();
        end

        // Drain: keep broadcasting so every pending source eventually wakes
        set_idle();
        bus.res_ready_i = 1'b1;
        for (int c = 0; c < 300 && (mq.size() > 0 || m_ov); c++) begin
            for (int p = 0; p < 2; p++) begin
                bus.wb_valid_i[p] = 1'b1;
                bus.wb_prd_i[p]   = 6'($urandom_range(0, 7));
                bus.wb_val_i[p]   = {$urandom, $urandom};
            end
            cyc();
        end
        set_idle();
        cyc();
        chk("drain_pending", 160'(sb.size()), 160'(0));
        chk("drain_queue", 160'(mq.size()), 160'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
